// File: rtl/apr_intc_pkg.sv
// Shared definitions for the APR interrupt controller: write-mode encodings,
// handshake FSM states and the level-to-request-vector decoder.
package apr_intc_pkg;

  // Microcode flag-write modes carried on wrMODE.
  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_SET  = 2'b01;
  localparam logic [1:0] MODE_CLR  = 2'b10;
  localparam logic [1:0] MODE_NOP  = 2'b11;

  // Request/acknowledge handshake states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } stateType;

  // Widest level field the decoder supports; callers truncate the result.
  localparam int MAXLVLW = 5;
  localparam int MAXREQ  = 2 ** MAXLVLW - 1;

  // One-hot request vector for a level. Level 1 sits in the MSB of an
  // nreq-wide vector and level nreq in the LSB (KS-10 PI numbering), so
  // level 3 of 7 reads 7'b0010000. Level 0 yields an all-zero vector.
  function automatic logic [MAXREQ-1:0] onehot(input logic [MAXLVLW-1:0] lvl,
                                               input int nreq);
    logic [MAXREQ-1:0] vec;
    vec = '0;
    for (int b = 0; b < MAXREQ; b++) begin
      if ((lvl != '0) && (b < nreq) && (int'(lvl) == nreq - b)) begin
        vec[b] = 1'b1;
      end
    end
    return vec;
  endfunction

endpackage

// File: rtl/apr_intc_if.sv
// Microcode write bus, hardware set sources and the CPU request/ack
// handshake of the APR interrupt controller, bundled as one interface.
interface apr_intc_if #(
  parameter int NFLAGS = 8,
  parameter int LVLW   = 3
);
  localparam int NREQ = 2 ** LVLW - 1;

  logic              clken;
  logic              wrFLAGS;
  logic [1:0]        wrMODE;
  logic [NFLAGS-1:0] flagDATA;
  logic              wrENABLE;
  logic [NFLAGS-1:0] enaDATA;
  logic              swintDATA;
  logic [LVLW-1:0]   levelDATA;
  logic [NFLAGS-1:0] hwSET;
  logic              intACK;
  logic [NFLAGS-1:0] flagsOUT;
  logic [NFLAGS-1:0] enaOUT;
  logic              intPEND;
  logic              intREQ;
  logic [NREQ-1:0]   aprINTR;

  // Controller side.
  modport slave (
    input  clken, wrFLAGS, wrMODE, flagDATA, wrENABLE, enaDATA,
           swintDATA, levelDATA, hwSET, intACK,
    output flagsOUT, enaOUT, intPEND, intREQ, aprINTR
  );

  // Microcode / CPU side.
  modport master (
    output clken, wrFLAGS, wrMODE, flagDATA, wrENABLE, enaDATA,
           swintDATA, levelDATA, hwSET, intACK,
    input  flagsOUT, enaOUT, intPEND, intREQ, aprINTR
  );
endinterface

// File: rtl/apr_intc_flag.sv
// One APR flag bit: hardware set (edge or level sensitive) with priority
// over the clock-enabled microcode load/set/clear write.
module apr_intc_flag
  import apr_intc_pkg::*;
#(
  parameter bit EDGE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       wrFlags,
  input  logic [1:0] wrMode,
  input  logic       dataBit,
  input  logic       hwSet,
  output logic       flag
);

  logic hwPrev;
  logic hwHit;
  logic flagReg;
  logic flagNext;

  // An edge-sensitive source only counts when its previous sample was low.
  always_comb begin
    hwHit = hwSet & (!EDGE || !hwPrev);
  end

  // Hardware set wins over any same-cycle microcode write.
  always_comb begin
    flagNext = flagReg;
    if (hwHit) begin
      flagNext = 1'b1;
    end else if (clken && wrFlags) begin
      case (wrMode)
        MODE_LOAD: flagNext = dataBit;
        MODE_SET:  flagNext = flagReg | dataBit;
        MODE_CLR:  flagNext = flagReg & ~dataBit;
        default:   flagNext = flagReg;
      endcase
    end
  end

  // Flag and source history; history tracks every cycle, clken or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flagReg <= 1'b0;
      hwPrev  <= 1'b0;
    end else begin
      flagReg <= flagNext;
      hwPrev  <= hwSet;
    end
  end

  assign flag = flagReg;

endmodule

// File: rtl/apr_intc.sv
// APR interrupt controller top: flag cells, enable/swint/level registers,
// pending OR and the registered request/ack handshake FSM.
module apr_intc
  import apr_intc_pkg::*;
#(
  parameter int                NFLAGS   = 8,
  parameter logic [NFLAGS-1:0] EDGEMASK = {NFLAGS{1'b0}},
  parameter int                LVLW     = 3
) (
  input logic        clk,
  input logic        rst,
  apr_intc_if.slave  bus
);

  localparam int NREQ = 2 ** LVLW - 1;

  logic [NFLAGS-1:0] flagsVec;
  logic [NFLAGS-1:0] enaReg;
  logic              swintReg;
  logic [LVLW-1:0]   levelReg;
  logic [LVLW-1:0]   reqLvlReg;
  logic [LVLW-1:0]   lvlSel;
  logic              intPend;
  logic              ackTake;
  logic              latchLvl;
  logic              reqReg;
  logic [NREQ-1:0]   aprIntrReg;
  logic [NREQ-1:0]   aprIntrNext;
  stateType          state;
  stateType          stateNext;

  genvar gi;
  generate
    for (gi = 0; gi < NFLAGS; gi++) begin : gFlag
      apr_intc_flag #(
        .EDGE (EDGEMASK[gi])
      ) uFlag (
        .clk     (clk),
        .rst     (rst),
        .clken   (bus.clken),
        .wrFlags (bus.wrFLAGS),
        .wrMode  (bus.wrMODE),
        .dataBit (bus.flagDATA[gi]),
        .hwSet   (bus.hwSET[gi]),
        .flag    (flagsVec[gi])
      );
    end
  endgenerate

  // Pending is the masked OR of the flags plus the software interrupt.
  always_comb begin
    intPend = (|(flagsVec & enaReg)) | swintReg;
  end

  // Handshake next-state; all transitions wait for clken.
  always_comb begin
    stateNext = state;
    ackTake   = 1'b0;
    latchLvl  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.clken && intPend && (levelReg != '0)) begin
          stateNext = ST_REQ;
          latchLvl  = 1'b1;
        end
      end
      ST_REQ: begin
        if (bus.clken) begin
          if (bus.intACK) begin
            stateNext = ST_HOLD;
            ackTake   = 1'b1;
          end else if (!intPend) begin
            stateNext = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (bus.clken) begin
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Request vector for the coming cycle: fresh level on entry, else the latch,
  // so level rewrites during a request do not disturb aprINTR.
  always_comb begin
    lvlSel      = latchLvl ? levelReg : reqLvlReg;
    aprIntrNext = '0;
    if (stateNext == ST_REQ) begin
      aprIntrNext = NREQ'(onehot(MAXLVLW'(lvlSel), NREQ));
    end
  end

  // State, latched level and registered request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      reqLvlReg  <= '0;
      reqReg     <= 1'b0;
      aprIntrReg <= '0;
    end else begin
      state      <= stateNext;
      reqLvlReg  <= lvlSel;
      reqReg     <= (stateNext == ST_REQ);
      aprIntrReg <= aprIntrNext;
    end
  end

  // Enable/swint/level load; an accepted ack clears swint unless rewritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enaReg   <= '0;
      swintReg <= 1'b0;
      levelReg <= '0;
    end else if (bus.clken && bus.wrENABLE) begin
      enaReg   <= bus.enaDATA;
      swintReg <= bus.swintDATA;
      levelReg <= bus.levelDATA;
    end else if (ackTake) begin
      swintReg <= 1'b0;
    end
  end

  assign bus.flagsOUT = flagsVec;
  assign bus.enaOUT   = enaReg;
  assign bus.intPEND  = intPend;
  assign bus.intREQ   = reqReg;
  assign bus.aprINTR  = aprIntrReg;

endmodule

// File: tb/tb_apr_intc.sv
// Self-checking bench for apr_intc: directed vector table, hand-written
// multi-cycle sequences and random stimulus against a behavioural model.
module tb_apr_intc;
  import apr_intc_pkg::*;

  localparam int NF = 8;
  localparam int LW = 3;
  localparam int NR = 7;
  localparam logic [NF-1:0] EM = 8'b1010_0100;

  logic clk;
  logic rst;

  apr_intc_if #(.NFLAGS(NF), .LVLW(LW)) bus ();

  apr_intc #(
    .NFLAGS   (NF),
    .EDGEMASK (EM),
    .LVLW     (LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [NF-1:0] mFlags, mEna, mPrev;
  logic          mSwint;
  int            mLevel, mReqLvl;
  bit            mReq, mHold;

  typedef struct {
    logic          wrF;
    logic [1:0]    mode;
    logic [NF-1:0] fd;
    logic          wrE;
    logic [NF-1:0] ed;
    logic          sw;
    logic [LW-1:0] lv;
    logic [NF-1:0] hw;
    logic          ack;
    logic [NF-1:0] eFlags;
    logic          ePend;
    logic          eReq;
    logic [NR-1:0] eApr;
  } vecType;

  vecType vt[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idleIn();
    bus.clken = 1'b1; bus.wrFLAGS = 1'b0; bus.wrMODE = MODE_NOP; bus.flagDATA = '0;
    bus.wrENABLE = 1'b0; bus.enaDATA = '0; bus.swintDATA = 1'b0; bus.levelDATA = '0;
    bus.hwSET = '0; bus.intACK = 1'b0;
  endtask

  task automatic modelReset();
    mFlags = '0; mEna = '0; mPrev = '0; mSwint = 1'b0;
    mLevel = 0; mReqLvl = 0; mReq = 0; mHold = 0;
  endtask

  function automatic logic [NR-1:0] mApr();
    logic [NR-1:0] one;
    one = 7'd1;
    return mReq ? (one << (NR - mReqLvl)) : '0;
  endfunction

  function automatic logic mPend();
    return (|(mFlags & mEna)) | mSwint;
  endfunction

  // Advance the model by one clock using the inputs presently driven.
  task automatic modelEdge();
    logic [NF-1:0] nf, hit;
    logic pend;
    bit ackTake;
    pend = mPend();
    hit  = bus.hwSET & ~(EM & mPrev);
    nf   = mFlags;
    if (bus.clken && bus.wrFLAGS) begin
      if (bus.wrMODE == MODE_LOAD) nf = bus.flagDATA;
      else if (bus.wrMODE == MODE_SET) nf = nf | bus.flagDATA;
      else if (bus.wrMODE == MODE_CLR) nf = nf & ~bus.flagDATA;
    end
    nf = nf | hit;
    ackTake = bus.clken && mReq && bus.intACK;
    if (bus.clken) begin
      if (mReq) begin
        if (bus.intACK) begin mReq = 0; mHold = 1; end
        else if (!pend) mReq = 0;
      end else if (mHold) begin
        mHold = 0;
      end else if (pend && mLevel != 0) begin
        mReq = 1; mReqLvl = mLevel;
      end
    end
    if (bus.clken && bus.wrENABLE) begin
      mEna = bus.enaDATA; mSwint = bus.swintDATA; mLevel = int'(bus.levelDATA);
    end else if (ackTake) begin
      mSwint = 1'b0;
    end
    mFlags = nf;
    mPrev  = bus.hwSET;
  endtask

  // One clock: model step, edge, then compare all outputs against the model.
  task automatic tick(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    check({tag, ".flags"}, 32'(bus.flagsOUT), 32'(mFlags));
    check({tag, ".ena"},   32'(bus.enaOUT),   32'(mEna));
    check({tag, ".pend"},  32'(bus.intPEND),  32'(mPend()));
    check({tag, ".req"},   32'(bus.intREQ),   32'(mReq));
    check({tag, ".apr"},   32'(bus.aprINTR),  32'(mApr()));
  endtask

  task automatic resetDut();
    rst = 1'b1;
    idleIn();
    repeat (2) @(posedge clk);
    #1;
    check("rst.flags", 32'(bus.flagsOUT), 32'h0);
    check("rst.ena",   32'(bus.enaOUT),   32'h0);
    check("rst.pend",  32'(bus.intPEND),  32'h0);
    check("rst.req",   32'(bus.intREQ),   32'h0);
    check("rst.apr",   32'(bus.aprINTR),  32'h0);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    rst = 1'b1;
    idleIn();
    modelReset();

    // wrF mode fd wrE ed sw lv hw ack | eFlags ePend eReq eApr
    vt[0]  = '{0, MODE_NOP,  8'h00, 1, 8'h01, 0, 3'd3, 8'h00, 0, 8'h00, 0, 0, 7'b0000000};
    vt[1]  = '{1, MODE_LOAD, 8'h01, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h01, 1, 0, 7'b0000000};
    vt[2]  = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h01, 1, 1, 7'b0010000};
    vt[3]  = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 1, 8'h01, 1, 0, 7'b0000000};
    vt[4]  = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h01, 1, 0, 7'b0000000};
    vt[5]  = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h01, 1, 1, 7'b0010000};
    vt[6]  = '{0, MODE_NOP,  8'h00, 1, 8'h01, 0, 3'd6, 8'h00, 0, 8'h01, 1, 1, 7'b0010000};
    vt[7]  = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 1, 8'h01, 1, 0, 7'b0000000};
    vt[8]  = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h01, 1, 0, 7'b0000000};
    vt[9]  = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h01, 1, 1, 7'b0000010};
    vt[10] = '{1, MODE_CLR,  8'h01, 0, 8'h00, 0, 3'd0, 8'h00, 1, 8'h00, 0, 0, 7'b0000000};
    vt[11] = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h00, 0, 0, 7'b0000000};
    vt[12] = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h00, 0, 0, 7'b0000000};
    vt[13] = '{1, MODE_CLR,  8'h01, 0, 8'h00, 0, 3'd0, 8'h01, 0, 8'h01, 1, 0, 7'b0000000};
    vt[14] = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h01, 1, 1, 7'b0000010};
    vt[15] = '{0, MODE_NOP,  8'h00, 1, 8'h00, 0, 3'd6, 8'h00, 0, 8'h01, 0, 1, 7'b0000010};
    vt[16] = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h01, 0, 0, 7'b0000000};
    vt[17] = '{0, MODE_NOP,  8'h00, 1, 8'h00, 1, 3'd1, 8'h00, 0, 8'h01, 1, 0, 7'b0000000};
    vt[18] = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h01, 1, 1, 7'b1000000};
    vt[19] = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 1, 8'h01, 0, 0, 7'b0000000};
    vt[20] = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h01, 0, 0, 7'b0000000};
    vt[21] = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h01, 0, 0, 7'b0000000};
    vt[22] = '{0, MODE_NOP,  8'h00, 1, 8'h01, 0, 3'd0, 8'h00, 0, 8'h01, 1, 0, 7'b0000000};
    vt[23] = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h01, 1, 0, 7'b0000000};
    vt[24] = '{0, MODE_NOP,  8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 8'h01, 1, 0, 7'b0000000};

    resetDut();

    // Directed table.
    for (int i = 0; i < 25; i++) begin
      idleIn();
      bus.wrFLAGS = vt[i].wrF;  bus.wrMODE = vt[i].mode;     bus.flagDATA = vt[i].fd;
      bus.wrENABLE = vt[i].wrE; bus.enaDATA = vt[i].ed;      bus.swintDATA = vt[i].sw;
      bus.levelDATA = vt[i].lv; bus.hwSET = vt[i].hw;        bus.intACK = vt[i].ack;
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d.tflags", i), 32'(bus.flagsOUT), 32'(vt[i].eFlags));
      check($sformatf("vec%0d.tpend", i),  32'(bus.intPEND),  32'(vt[i].ePend));
      check($sformatf("vec%0d.treq", i),   32'(bus.intREQ),   32'(vt[i].eReq));
      check($sformatf("vec%0d.tapr", i),   32'(bus.aprINTR),  32'(vt[i].eApr));
      $display("vec %0d: flags=%h pend=%b req=%b apr=%b", i, bus.flagsOUT, bus.intPEND,
               bus.intREQ, bus.aprINTR);
    end

    // Edge flag 2 vs level flag 3 with sources held high, clear at cycle 5.
    resetDut();
    for (int c = 0; c < 10; c++) begin
      idleIn();
      bus.hwSET = 8'h0C;
      if (c == 5) begin
        bus.wrFLAGS = 1'b1; bus.wrMODE = MODE_CLR; bus.flagDATA = 8'h0C;
      end
      tick($sformatf("edge%0d", c));
      if (c == 0) check("edge.first", 32'(bus.flagsOUT[2]), 32'h1);
      $display("edge seq cycle %0d: flags=%h", c, bus.flagsOUT);
    end
    check("edge.noreedge", 32'(bus.flagsOUT[2]), 32'h0);
    check("lvl.hwwins",    32'(bus.flagsOUT[3]), 32'h1);
    idleIn();
    tick("edge.low");
    idleIn();
    bus.hwSET = 8'h04;
    tick("edge.rise");
    check("edge.reset", 32'(bus.flagsOUT[2]), 32'h1);
    $display("edge seq re-edge: flags=%h", bus.flagsOUT);

    // clken low freezes writes and FSM but hardware sets still land.
    idleIn();
    bus.wrENABLE = 1'b1; bus.enaDATA = 8'h04; bus.levelDATA = 3'd2;
    tick("cke.arm");
    idleIn();
    bus.clken = 1'b0; bus.wrFLAGS = 1'b1; bus.wrMODE = MODE_CLR; bus.flagDATA = 8'hFF;
    bus.hwSET = 8'h01;
    tick("cke.frz0");
    tick("cke.frz1");
    check("cke.noreq", 32'(bus.intREQ), 32'h0);
    check("cke.flags", 32'(bus.flagsOUT), 32'h0D);
    idleIn();
    tick("cke.go");
    check("cke.req", 32'(bus.aprINTR), 32'b0100000);
    $display("clken seq: flags=%h req=%b apr=%b", bus.flagsOUT, bus.intREQ, bus.aprINTR);

    // Asynchronous reset mid-request drops outputs without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst.req",   32'(bus.intREQ),   32'h0);
    check("arst.apr",   32'(bus.aprINTR),  32'h0);
    check("arst.pend",  32'(bus.intPEND),  32'h0);
    check("arst.flags", 32'(bus.flagsOUT), 32'h0);
    $display("async reset: req=%b apr=%b", bus.intREQ, bus.aprINTR);
    resetDut();

    // Random stimulus against the model.
    for (int n = 0; n < 600; n++) begin
      idleIn();
      bus.clken     = ($urandom_range(0, 9) != 0);
      bus.wrFLAGS   = ($urandom_range(0, 3) == 0);
      bus.wrMODE    = 2'($urandom_range(0, 3));
      bus.flagDATA  = 8'($urandom);
      bus.wrENABLE  = ($urandom_range(0, 6) == 0);
      bus.enaDATA   = 8'($urandom);
      bus.swintDATA = ($urandom_range(0, 3) == 0);
      bus.levelDATA = 3'($urandom_range(0, 7));
      bus.hwSET     = 8'($urandom) & 8'($urandom) & 8'($urandom);
      bus.intACK    = ($urandom_range(0, 2) == 0);
      tick($sformatf("rnd%0d", n));
      $display("rnd %0d: flags=%h ena=%h pend=%b req=%b apr=%b", n, bus.flagsOUT,
               bus.enaOUT, bus.intPEND, bus.intREQ, bus.aprINTR);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
